sum_bcd_display: RTL



---
 rtl/sum_display_pkg.sv | 31 +++
 rtl/seg7_decode.sv | 30 +++
 rtl/sum_bcd_display.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sum_display_pkg.sv
// Shared widths, FSM state type and segment constants for the sum result/display stage.
// Also holds the double-dabble nibble adjust used by the conversion engine.
package sum_display_pkg;

  localparam int SUM_W      = 16;
  localparam int NUM_DIGITS = 5;
  localparam int BCD_W      = 20;
  localparam int SHIFT_W    = BCD_W + SUM_W;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_t;

  // Active-low segments, bit order g f e d c b a.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder (g f e d c b a).
// Blank input or any non-decimal nibble turns every segment off.
module seg7_decode
  import sum_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SEG_BLANK;
    if (!i_blank) begin
      case (i_digit)
        4'd0:    o_seg_n = SEG_ZERO;
        4'd1:    o_seg_n = 7'b1111001;
        4'd2:    o_seg_n = 7'b0100100;
        4'd3:    o_seg_n = 7'b0110000;
        4'd4:    o_seg_n = 7'b0011001;
        4'd5:    o_seg_n = 7'b0010010;
        4'd6:    o_seg_n = 7'b0000010;
        4'd7:    o_seg_n = 7'b1111000;
        4'd8:    o_seg_n = 7'b0000000;
        4'd9:    o_seg_n = 7'b0010000;
        default: o_seg_n = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sum_bcd_display.sv
// Captures the calculator sum on a rising done edge, converts it to 5 BCD digits
// (one double-dabble bit per cycle) and scans the held result onto a 5-digit display.
module sum_bcd_display
  import sum_display_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk_data,
  input  logic              rst,
  input  logic              done_in,
  input  logic [SUM_W-1:0]  sum_in,
  output logic              busy,
  output logic              bcd_valid,
  output logic [BCD_W-1:0]  bcd_out,
  output logic [6:0]        seg_n,
  output logic [4:0]        an_n,
  output conv_state_t       dbg_state
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Handshake: a request is the rising edge of done_in; it is accepted only in IDLE.
  // Requests seen while busy are discarded, never queued.
  conv_state_t        r_state;
  conv_state_t        w_state_next;
  logic               r_done_q;
  logic               w_req;
  logic               w_last_bit;
  logic [SHIFT_W-1:0] r_shift;
  logic [SHIFT_W-1:0] w_shift_adj;
  logic [SHIFT_W-1:0] w_shift_next;
  logic [3:0]         r_bit_cnt;
  logic [BCD_W-1:0]   r_bcd_out;
  logic               r_bcd_valid;

  logic [DIV_W-1:0]   r_div_cnt;
  logic [2:0]         r_digit_idx;
  logic [3:0]         w_nibble;
  logic               w_blank;
  logic [6:0]         w_seg_n;
  logic [4:0]         w_an_n;
  logic [6:0]         r_seg_n;
  logic [4:0]         r_an_n;

  assign w_req        = done_in & ~r_done_q;
  assign w_last_bit   = (r_bit_cnt == 4'd15);
  assign w_shift_adj  = {dabble_adjust(r_shift[SHIFT_W-1:SUM_W]), r_shift[SUM_W-1:0]};
  assign w_shift_next = {w_shift_adj[SHIFT_W-2:0], 1'b0};

  // FSM state register
  always_ff @(posedge clk_data) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_state_next = CONV;
      CONV:    if (w_last_bit) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (r_state == CONV);
    dbg_state = r_state;
  end

  // Conversion datapath
  always_ff @(posedge clk_data) begin
    if (rst) begin
      r_done_q    <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_bcd_out   <= '0;
      r_bcd_valid <= 1'b0;
    end else begin
      r_done_q    <= done_in;
      r_bcd_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (w_req) begin
          r_shift   <= {{BCD_W{1'b0}}, sum_in};
          r_bit_cnt <= '0;
        end
      end else begin
        r_shift   <= w_shift_next;
        r_bit_cnt <= r_bit_cnt + 4'd1;
        if (w_last_bit) begin
          r_bcd_out   <= w_shift_next[SHIFT_W-1:SUM_W];
          r_bcd_valid <= 1'b1;
        end
      end
    end
  end

  // Scan timing
  always_ff @(posedge clk_data) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_digit_idx <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt   <= '0;
      r_digit_idx <= (r_digit_idx == 3'd4) ? 3'd0 : r_digit_idx + 3'd1;
    end else begin
      r_div_cnt   <= r_div_cnt + 1'b1;
    end
  end

  // Digit mux; a digit blanks when it and every more significant digit are zero.
  always_comb begin
    w_nibble = r_bcd_out[3:0];
    w_blank  = 1'b0;
    case (r_digit_idx)
      3'd1: begin
        w_nibble = r_bcd_out[7:4];
        w_blank  = (r_bcd_out[19:4] == 16'd0);
      end
      3'd2: begin
        w_nibble = r_bcd_out[11:8];
        w_blank  = (r_bcd_out[19:8] == 12'd0);
      end
      3'd3: begin
        w_nibble = r_bcd_out[15:12];
        w_blank  = (r_bcd_out[19:12] == 8'd0);
      end
      3'd4: begin
        w_nibble = r_bcd_out[19:16];
        w_blank  = (r_bcd_out[19:16] == 4'd0);
      end
      default: begin
        w_nibble = r_bcd_out[3:0];
        w_blank  = 1'b0;
      end
    endcase
  end

  assign w_an_n = ~(5'b00001 << r_digit_idx);

  seg7_decode u_decode (
    .i_digit (w_nibble),
    .i_blank (w_blank),
    .o_seg_n (w_seg_n)
  );

  // Enable and segments share one register stage so they always switch together.
  always_ff @(posedge clk_data) begin
    if (rst) begin
      r_an_n  <= 5'b11110;
      r_seg_n <= SEG_ZERO;
    end else begin
      r_an_n  <= w_an_n;
      r_seg_n <= w_seg_n;
    end
  end

  assign bcd_out   = r_bcd_out;
  assign bcd_valid = r_bcd_valid;
  assign seg_n     = r_seg_n;
  assign an_n      = r_an_n;

endmodule
